// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and engine state types
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  // EXOKAY is accepted as success; only SLVERR and DECERR count as errors.
  function automatic logic resp_is_ok(input logic [1:0] resp);
    logic ok;
    unique case (resp)
      RESP_OKAY, RESP_EXOKAY:   ok = 1'b1;
      RESP_SLVERR, RESP_DECERR: ok = 1'b0;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/axi_lite_fifo_master.sv
// rtl/axi_lite_fifo_master.sv - AXI4-Lite manager moving words between local FIFOs and a subordinate
module axi_lite_fifo_master
  import axi_lite_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 8,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int unsigned WR_BASE_ADDR   = 0,
  parameter int unsigned RD_BASE_ADDR   = 0,
  parameter bit          ADDR_INC       = 1'b0,
  parameter bit          RETRY_ON_ERR   = 1'b1
) (
  input  logic                        aclk,
  input  logic                        areset,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   in_fifo_rd_data,
  output logic                        in_fifo_rd_en,
  input  logic                        in_fifo_empty,
  output logic [AXI_DATA_WIDTH-1:0]   out_fifo_wr_data,
  output logic                        out_fifo_wr_en,
  input  logic                        out_fifo_full,
  input  logic                        rd_enable,
  output logic [15:0]                 wr_err_count,
  output logic [15:0]                 rd_err_count,
  output logic                        busy
);

  localparam logic [AXI_ADDR_WIDTH-1:0] WR_BASE   = AXI_ADDR_WIDTH'(WR_BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] RD_BASE   = AXI_ADDR_WIDTH'(RD_BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

  w_state_e                  w_state_q, w_state_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      wr_err_inc;

  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                      rd_err_inc;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      waddr_q   <= WR_BASE;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= R_IDLE;
      raddr_q   <= RD_BASE;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
    end
  end

  // AW and W complete independently; the done flags remember which has already handshaked.
  always_comb begin
    w_state_d     = w_state_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    in_fifo_rd_en = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    wr_err_inc    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (!in_fifo_empty && !areset) begin
          in_fifo_rd_en = 1'b1;
          wdata_d       = in_fifo_rd_data;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          w_state_d     = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        aw_done_d     = aw_done_q | m_axi_awready;
        w_done_d      = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (resp_is_ok(m_axi_bresp)) begin
            if (ADDR_INC) waddr_d = waddr_q + ADDR_STEP;
            w_state_d = W_IDLE;
          end else begin
            wr_err_inc = 1'b1;
            if (RETRY_ON_ERR) begin
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
              w_state_d = W_ADDR;
            end else begin
              w_state_d = W_IDLE;
            end
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Fullness is checked only at issue; as sole writer, the slot stays free until the push.
  always_comb begin
    r_state_d      = r_state_q;
    raddr_d        = raddr_q;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    out_fifo_wr_en = 1'b0;
    rd_err_inc     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_enable && !out_fifo_full) r_state_d = R_ADDR;
      end
      R_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          if (resp_is_ok(m_axi_rresp)) begin
            out_fifo_wr_en = 1'b1;
            if (ADDR_INC) raddr_d = raddr_q + ADDR_STEP;
          end else begin
            rd_err_inc = 1'b1;
          end
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  sat_counter #(.WIDTH(16)) u_wr_err_cnt (
    .clk_i   (aclk),
    .rst_i   (areset),
    .inc_i   (wr_err_inc),
    .count_o (wr_err_count)
  );

  sat_counter #(.WIDTH(16)) u_rd_err_cnt (
    .clk_i   (aclk),
    .rst_i   (areset),
    .inc_i   (rd_err_inc),
    .count_o (rd_err_count)
  );

  assign m_axi_awaddr     = waddr_q;
  assign m_axi_wdata      = wdata_q;
  assign m_axi_wstrb      = '1;
  assign m_axi_araddr     = raddr_q;
  assign out_fifo_wr_data = m_axi_rdata;
  assign busy             = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_lite_fifo_master.sv
// tb/tb_axi_lite_fifo_master.sv - self-checking bench for axi_lite_fifo_master
module tb_axi_lite_fifo_master;

  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10;

  logic clk = 1'b0;
  logic areset, clr;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus knobs, owned by the initial block.
  logic        awready_cfg [2], wready_cfg [2], arready_cfg [2];
  logic        rd_enable_cfg [2], out_full_cfg [2];
  logic [1:0]  bresp_ok_cfg [2];
  int          b_err_n [2], r_err_n [2];
  logic [31:0] rdata_cfg [2];
  logic [31:0] in_mem [2][16];
  int          in_wp [2];

  // Observations exported from each instance.
  logic        awvalid_a [2], wvalid_a [2], bready_a [2], arvalid_a [2], rready_a [2];
  logic        rd_en_a [2], wr_en_a [2], busy_a [2];
  logic [7:0]  awaddr_a [2], araddr_a [2];
  logic [3:0]  wstrb_a [2];
  logic [15:0] wr_err_a [2], rd_err_a [2];
  logic [31:0] out_data_a [2];
  int          aw_n_a [2], w_n_a [2], b_n_a [2], ar_n_a [2], push_n_a [2], pop_n_a [2];
  logic [7:0]  last_aw_a [2];
  logic [31:0] last_w_a [2];
  logic        aw_chg_a [2], w_chg_a [2], ar_seen_a [2];

  for (genvar g = 0; g < 2; g++) begin : sub
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata, in_rd_data, out_wr_data;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, wvalid, bvalid, bready, arvalid, rvalid, rready;
    logic        in_rd_en, in_empty, out_wr_en, busy;
    logic [15:0] wr_err, rd_err;
    int          aw_n, w_n, b_n, ar_n, push_n, pop_n, b_iss, r_iss, rp;
    logic [7:0]  aw_addr [16], ar_addr [16];
    logic [31:0] w_data [16], push_data [16];
    int          pop_cyc [16];
    logic        aw_p, w_p, aw_chg, w_chg, ar_seen;

    axi_lite_fifo_master #(
      .AXI_ADDR_WIDTH (8),
      .AXI_DATA_WIDTH (32),
      .WR_BASE_ADDR   (g == 0 ? 32'h10 : 32'h20),
      .RD_BASE_ADDR   (0),
      .ADDR_INC       (g == 1),
      .RETRY_ON_ERR   (g == 0)
    ) dut (
      .aclk (clk), .areset (areset),
      .m_axi_awaddr (awaddr), .m_axi_awvalid (awvalid), .m_axi_awready (awready_cfg[g]),
      .m_axi_wdata (wdata), .m_axi_wstrb (wstrb), .m_axi_wvalid (wvalid), .m_axi_wready (wready_cfg[g]),
      .m_axi_bresp (bresp), .m_axi_bvalid (bvalid), .m_axi_bready (bready),
      .m_axi_araddr (araddr), .m_axi_arvalid (arvalid), .m_axi_arready (arready_cfg[g]),
      .m_axi_rdata (rdata), .m_axi_rresp (rresp), .m_axi_rvalid (rvalid), .m_axi_rready (rready),
      .in_fifo_rd_data (in_rd_data), .in_fifo_rd_en (in_rd_en), .in_fifo_empty (in_empty),
      .out_fifo_wr_data (out_wr_data), .out_fifo_wr_en (out_wr_en), .out_fifo_full (out_full_cfg[g]),
      .rd_enable (rd_enable_cfg[g]), .wr_err_count (wr_err), .rd_err_count (rd_err), .busy (busy)
    );

    assign in_empty   = (rp >= in_wp[g]);
    assign in_rd_data = in_mem[g][rp % 16];

    // Subordinate model: registered B and R responses, first N responses answered SLVERR.
    always @(posedge clk) begin
      if (clr) begin
        aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; push_n <= 0; pop_n <= 0;
        b_iss <= 0; r_iss <= 0; rp <= 0;
        bvalid <= 1'b0; rvalid <= 1'b0; bresp <= OKAY; rresp <= OKAY; rdata <= '0;
        aw_p <= 1'b0; w_p <= 1'b0; aw_chg <= 1'b0; w_chg <= 1'b0; ar_seen <= 1'b0;
      end else begin
        if (awvalid && awready_cfg[g]) begin
          if (aw_n > 0 && awaddr != aw_addr[(aw_n - 1) % 16]) aw_chg <= 1'b1;
          aw_addr[aw_n % 16] <= awaddr;
          aw_n <= aw_n + 1;
        end
        if (wvalid && wready_cfg[g]) begin
          if (w_n > 0 && wdata != w_data[(w_n - 1) % 16]) w_chg <= 1'b1;
          w_data[w_n % 16] <= wdata;
          w_n <= w_n + 1;
        end
        if (bvalid && bready) begin
          bvalid <= 1'b0;
          b_n <= b_n + 1;
        end else if (!bvalid && (aw_p || (awvalid && awready_cfg[g])) && (w_p || (wvalid && wready_cfg[g]))) begin
          bvalid <= 1'b1;
          bresp  <= (b_iss < b_err_n[g]) ? SLVERR : bresp_ok_cfg[g];
          b_iss  <= b_iss + 1;
          aw_p   <= 1'b0;
          w_p    <= 1'b0;
        end else begin
          if (awvalid && awready_cfg[g]) aw_p <= 1'b1;
          if (wvalid && wready_cfg[g]) w_p <= 1'b1;
        end
        if (arvalid) ar_seen <= 1'b1;
        if (arvalid && arready_cfg[g]) begin
          ar_addr[ar_n % 16] <= araddr;
          ar_n <= ar_n + 1;
        end
        if (rvalid && rready) begin
          rvalid <= 1'b0;
        end else if (!rvalid && arvalid && arready_cfg[g]) begin
          rvalid <= 1'b1;
          rresp  <= (r_iss < r_err_n[g]) ? SLVERR : OKAY;
          rdata  <= rdata_cfg[g];
          r_iss  <= r_iss + 1;
        end
        if (out_wr_en) begin
          push_data[push_n % 16] <= out_wr_data;
          push_n <= push_n + 1;
        end
        if (in_rd_en) begin
          pop_cyc[pop_n % 16] <= cyc;
          pop_n <= pop_n + 1;
          rp <= rp + 1;
        end
      end
    end

    assign awvalid_a[g] = awvalid;  assign wvalid_a[g] = wvalid;  assign bready_a[g] = bready;
    assign arvalid_a[g] = arvalid;  assign rready_a[g] = rready;  assign rd_en_a[g] = in_rd_en;
    assign wr_en_a[g] = out_wr_en;  assign busy_a[g] = busy;      assign awaddr_a[g] = awaddr;
    assign araddr_a[g] = araddr;    assign wstrb_a[g] = wstrb;    assign wr_err_a[g] = wr_err;
    assign rd_err_a[g] = rd_err;    assign out_data_a[g] = out_wr_data;
    assign aw_n_a[g] = aw_n;        assign w_n_a[g] = w_n;        assign b_n_a[g] = b_n;
    assign ar_n_a[g] = ar_n;        assign push_n_a[g] = push_n;  assign pop_n_a[g] = pop_n;
    assign last_aw_a[g] = aw_addr[(aw_n + 15) % 16];
    assign last_w_a[g]  = w_data[(w_n + 15) % 16];
    assign aw_chg_a[g] = aw_chg;    assign w_chg_a[g] = w_chg;    assign ar_seen_a[g] = ar_seen;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int cnt(input int g, input int sel);
    return (sel == 0) ? b_n_a[g] : push_n_a[g];
  endfunction

  task automatic wait_cnt(input string nm, input int g, input int sel, input int target);
    int k = 0;
    while (cnt(g, sel) < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, cnt(g, sel) >= target, 1);
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    in_wp[0] = 0;
    in_wp[1] = 0;
    tick(1);
    clr = 1'b0;
  endtask

  typedef struct {
    int          g;
    logic [31:0] data;
    logic [1:0]  ok_resp;
    int          nerr;
    int          exp_b;
    logic [7:0]  exp_addr;
    logic [15:0] exp_err;
    logic [7:0]  exp_next;
  } wvec_t;

  wvec_t wv [6];

  initial begin
    wv[0] = '{0, 32'hA5A50001, OKAY,   0, 1, 8'h10, 16'd0, 8'h10};
    wv[1] = '{0, 32'h0BADF00D, OKAY,   1, 2, 8'h10, 16'd1, 8'h10};
    wv[2] = '{0, 32'h5555AAAA, EXOKAY, 2, 3, 8'h10, 16'd3, 8'h10};
    wv[3] = '{1, 32'h11111111, EXOKAY, 0, 1, 8'h20, 16'd0, 8'h24};
    wv[4] = '{1, 32'h22222222, OKAY,   1, 1, 8'h24, 16'd1, 8'h24};
    wv[5] = '{1, 32'h33333333, OKAY,   0, 1, 8'h24, 16'd1, 8'h28};

    areset = 1'b1;
    clr    = 1'b1;
    for (int g = 0; g < 2; g++) begin
      awready_cfg[g] = 1'b1; wready_cfg[g] = 1'b1; arready_cfg[g] = 1'b1;
      rd_enable_cfg[g] = 1'b0; out_full_cfg[g] = 1'b0; bresp_ok_cfg[g] = OKAY;
      b_err_n[g] = 0; r_err_n[g] = 0; rdata_cfg[g] = '0; in_wp[g] = 0;
    end
    tick(3);

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_awvalid%0d", g), awvalid_a[g], 0);
      chk($sformatf("rst_wvalid%0d", g), wvalid_a[g], 0);
      chk($sformatf("rst_bready%0d", g), bready_a[g], 0);
      chk($sformatf("rst_arvalid%0d", g), arvalid_a[g], 0);
      chk($sformatf("rst_rready%0d", g), rready_a[g], 0);
      chk($sformatf("rst_pop%0d", g), rd_en_a[g], 0);
      chk($sformatf("rst_push%0d", g), wr_en_a[g], 0);
      chk($sformatf("rst_busy%0d", g), busy_a[g], 0);
      chk($sformatf("rst_wr_err%0d", g), wr_err_a[g], 0);
      chk($sformatf("rst_rd_err%0d", g), rd_err_a[g], 0);
      chk($sformatf("rst_awaddr%0d", g), awaddr_a[g], (g == 0) ? 8'h10 : 8'h20);
      chk($sformatf("rst_araddr%0d", g), araddr_a[g], 8'h00);
      chk($sformatf("rst_wstrb%0d", g), wstrb_a[g], 4'hF);
    end
    areset = 1'b0;
    clr    = 1'b0;
    tick(1);

    // Table: one word per vector, with a scheduled number of error responses first.
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      b_err_n[wv[i].g]      = wv[i].nerr;
      bresp_ok_cfg[wv[i].g] = wv[i].ok_resp;
      in_mem[wv[i].g][0]    = wv[i].data;
      in_wp[wv[i].g]        = 1;
      wait_cnt($sformatf("v%0d_b_timeout", i), wv[i].g, 0, wv[i].exp_b);
      tick(2);
      chk($sformatf("v%0d_b_count", i), b_n_a[wv[i].g], wv[i].exp_b);
      chk($sformatf("v%0d_aw_count", i), aw_n_a[wv[i].g], wv[i].exp_b);
      chk($sformatf("v%0d_w_count", i), w_n_a[wv[i].g], wv[i].exp_b);
      chk($sformatf("v%0d_pops", i), pop_n_a[wv[i].g], 1);
      chk($sformatf("v%0d_addr", i), last_aw_a[wv[i].g], wv[i].exp_addr);
      chk($sformatf("v%0d_data", i), last_w_a[wv[i].g], wv[i].data);
      chk($sformatf("v%0d_same_beat", i), {aw_chg_a[wv[i].g], w_chg_a[wv[i].g]}, 2'b00);
      chk($sformatf("v%0d_err_count", i), wr_err_a[wv[i].g], wv[i].exp_err);
      chk($sformatf("v%0d_next_addr", i), awaddr_a[wv[i].g], wv[i].exp_next);
      chk($sformatf("v%0d_idle", i), busy_a[wv[i].g], 0);
    end
    b_err_n[0] = 0; b_err_n[1] = 0;
    bresp_ok_cfg[0] = OKAY; bresp_ok_cfg[1] = OKAY;

    // Three queued words: in order, fixed address, pops three cycles apart.
    clear_logs();
    for (int k = 0; k < 3; k++) in_mem[0][k] = 32'hA5A50001 + k;
    in_wp[0] = 3;
    wait_cnt("burst_b_timeout", 0, 0, 3);
    tick(2);
    chk("burst_pops", pop_n_a[0], 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("burst_data%0d", k), sub[0].w_data[k], 32'hA5A50001 + k);
      chk($sformatf("burst_addr%0d", k), sub[0].aw_addr[k], 8'h10);
    end
    chk("burst_gap01", sub[0].pop_cyc[1] - sub[0].pop_cyc[0], 3);
    chk("burst_gap12", sub[0].pop_cyc[2] - sub[0].pop_cyc[1], 3);

    // AW stalled while W completes.
    clear_logs();
    awready_cfg[0] = 1'b0;
    in_mem[0][0] = 32'h0000BEEF;
    in_wp[0] = 1;
    tick(1);
    chk("stall_aw_up", awvalid_a[0], 1);
    chk("stall_w_up", wvalid_a[0], 1);
    tick(1);
    chk("stall_w_dropped", wvalid_a[0], 0);
    chk("stall_aw_held", awvalid_a[0], 1);
    tick(3);
    chk("stall_aw_still", awvalid_a[0], 1);
    chk("stall_w_once", w_n_a[0], 1);
    chk("stall_no_b", b_n_a[0], 0);
    awready_cfg[0] = 1'b1;
    wait_cnt("stall_b_timeout", 0, 0, 1);
    tick(3);
    chk("stall_one_b", b_n_a[0], 1);
    chk("stall_one_aw", aw_n_a[0], 1);
    chk("stall_idle", busy_a[0], 0);

    // Single OKAY read into the output FIFO.
    clear_logs();
    rdata_cfg[0] = 32'hDEADBEEF;
    rd_enable_cfg[0] = 1'b1;
    tick(1);
    chk("rd_arvalid", arvalid_a[0], 1);
    tick(1);
    chk("rd_rready", rready_a[0], 1);
    chk("rd_push", wr_en_a[0], 1);
    chk("rd_push_data", out_data_a[0], 32'hDEADBEEF);
    rd_enable_cfg[0] = 1'b0;
    tick(3);
    chk("rd_one_push", push_n_a[0], 1);
    chk("rd_addr_fixed", araddr_a[0], 8'h00);
    chk("rd_idle", busy_a[0], 0);

    // Incrementing read address.
    clear_logs();
    rdata_cfg[1] = 32'h01020304;
    rd_enable_cfg[1] = 1'b1;
    wait_cnt("rdinc_timeout", 1, 1, 2);
    rd_enable_cfg[1] = 1'b0;
    tick(4);
    chk("rdinc_addr0", sub[1].ar_addr[0], 8'h00);
    chk("rdinc_addr1", sub[1].ar_addr[1], 8'h04);
    chk("rdinc_data", sub[1].push_data[1], 32'h01020304);
    chk("rdinc_next", araddr_a[1], 8'((push_n_a[1] * 4) % 256));

    // Full output FIFO blocks issue.
    clear_logs();
    out_full_cfg[0] = 1'b1;
    rd_enable_cfg[0] = 1'b1;
    tick(6);
    chk("full_no_arvalid", ar_seen_a[0], 0);
    chk("full_no_ar", ar_n_a[0], 0);
    rd_enable_cfg[0] = 1'b0;
    out_full_cfg[0] = 1'b0;
    tick(1);

    // Read error; rd_enable drops while the read is in flight.
    clear_logs();
    r_err_n[0] = 1;
    rd_enable_cfg[0] = 1'b1;
    tick(1);
    rd_enable_cfg[0] = 1'b0;
    tick(1);
    chk("rderr_no_push", wr_en_a[0], 0);
    tick(2);
    chk("rderr_pushes", push_n_a[0], 0);
    chk("rderr_count", rd_err_a[0], 1);
    chk("rderr_ar_done", ar_n_a[0], 1);
    chk("rderr_idle", busy_a[0], 0);
    r_err_n[0] = 0;

    // Reset during W_RESP.
    clear_logs();
    in_mem[0][0] = 32'h77770000;
    in_wp[0] = 1;
    tick(2);
    chk("arst_in_resp", bready_a[0], 1);
    areset = 1'b1;
    tick(1);
    chk("arst_awvalid", awvalid_a[0], 0);
    chk("arst_wvalid", wvalid_a[0], 0);
    chk("arst_bready", bready_a[0], 0);
    chk("arst_awaddr", awaddr_a[0], 8'h10);
    chk("arst_wr_err", wr_err_a[0], 0);
    chk("arst_rd_err", rd_err_a[0], 0);
    chk("arst_busy", busy_a[0], 0);
    chk("arst_pop", rd_en_a[0], 0);
    areset = 1'b0;
    tick(5);
    chk("arst_no_extra_pop", pop_n_a[0], 1);
    chk("arst_no_reissue", aw_n_a[0], 1);
    chk("arst_stays_idle", busy_a[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
